// File: rtl/frame_renderer_if.sv
// Game-state and VGA output bundle between the game-logic stage, the frame
// renderer and the board pins.
interface frame_renderer_if;
  logic [15:0] bird_y;
  logic [31:0] pipe1;
  logic [31:0] pipe2;
  logic [31:0] pipe3;
  logic [31:0] coin;
  logic [1:0]  status;
  logic        hs;
  logic        vs;
  logic [11:0] rgb;
  logic        frame_start;

  modport master (
    output bird_y, pipe1, pipe2, pipe3, coin, status,
    input  hs, vs, rgb, frame_start
  );

  modport slave (
    input  bird_y, pipe1, pipe2, pipe3, coin, status,
    output hs, vs, rgb, frame_start
  );
endinterface

// File: rtl/frame_renderer.sv
// VGA timing generator and one-stage pixel pipeline drawing the game state,
// which is latched once per frame at the start of vertical blank.
module frame_renderer #(
  parameter int          PIX_DIV  = 4,
  parameter logic [11:0] COL_SKY  = 12'h7CF,
  parameter logic [11:0] COL_PIPE = 12'h2A2,
  parameter logic [11:0] COL_BIRD = 12'hFD0,
  parameter logic [11:0] COL_COIN = 12'hFA0,
  parameter logic [11:0] COL_DUAL = 12'h00F,
  parameter int          H_VIS    = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_VIS    = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  frame_renderer_if.slave bus
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]  HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]  H_EDGE   = 10'(H_VIS - 5);
  localparam logic [9:0]  V_EDGE   = 10'(V_VIS - 5);
  localparam logic [9:0]  Y_TOP    = 10'(V_VIS - 1);
  localparam logic [10:0] BIRD_L   = 11'd40;
  localparam logic [10:0] BIRD_R   = 11'd55;

  logic [DIV_W-1:0] div_q;
  logic [9:0]  hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic        tick, latch;

  logic [9:0]  birdY_q;
  logic [27:0] pipe1_q, pipe2_q, pipe3_q;
  logic        coinVis_q;
  logic [19:0] coin_q;
  logic [1:0]  status_q;

  logic        hs_q, vs_q, frameStart_q;
  logic [11:0] rgb_q;
  logic        hs_d, vs_d;
  logic [11:0] rgb_d;

  logic [10:0] pxH, pxY;
  logic        visible, border, birdHit, coinHit, pipeAny;

  logic unused_ok;
  assign unused_ok = ^{bus.bird_y[15:10], bus.pipe1[31:28], bus.pipe2[31:28],
                       bus.pipe3[31:28], bus.coin[30:20]};

  // All compares are 11 bits wide so right/top edges never wrap past 1023.
  function automatic logic pipeHit(input logic [27:0] p, input logic [10:0] x,
                                   input logic [10:0] y);
    logic [10:0] left, gapLo, gapHi;
    left  = {1'b0, p[19:10]};
    gapLo = {1'b0, p[9:0]};
    gapHi = gapLo + {3'b000, p[27:20]};
    return (x >= left) && (x <= left + 11'd49) && ((y <= gapLo) || (y >= gapHi));
  endfunction

  always_comb begin
    tick   = (div_q == DIV_LAST);
    latch  = tick && (hcnt_q == 10'd0) && (vcnt_q == V_VIS_C);
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  always_comb begin
    pxH     = {1'b0, hcnt_q};
    pxY     = {1'b0, Y_TOP - vcnt_q};
    visible = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    border  = (status_q == 2'b11) &&
              ((hcnt_q < 10'd4) || (hcnt_q > H_EDGE) || (vcnt_q < 10'd4) || (vcnt_q > V_EDGE));
    birdHit = (pxH >= BIRD_L) && (pxH <= BIRD_R) &&
              (pxY >= {1'b0, birdY_q}) && (pxY <= {1'b0, birdY_q} + 11'd15);
    coinHit = coinVis_q &&
              (pxH >= {1'b0, coin_q[9:0]}) && (pxH <= {1'b0, coin_q[9:0]} + 11'd15) &&
              (pxY >= {1'b0, coin_q[19:10]}) && (pxY <= {1'b0, coin_q[19:10]} + 11'd15);
    pipeAny = pipeHit(pipe1_q, pxH, pxY) || pipeHit(pipe2_q, pxH, pxY) ||
              pipeHit(pipe3_q, pxH, pxY);

    rgb_d = COL_SKY;
    if (!visible)     rgb_d = 12'h000;
    else if (border)  rgb_d = COL_DUAL;
    else if (birdHit) rgb_d = COL_BIRD;
    else if (coinHit) rgb_d = COL_COIN;
    else if (pipeAny) rgb_d = COL_PIPE;

    hs_d = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vs_d = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
  end

  // Colour and syncs share one register stage so they leave aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q        <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      rgb_q        <= '0;
      frameStart_q <= 1'b0;
      birdY_q      <= 10'd240;
      pipe1_q      <= '0;
      pipe2_q      <= '0;
      pipe3_q      <= '0;
      coinVis_q    <= 1'b0;
      coin_q       <= '0;
      status_q     <= 2'b00;
    end else begin
      frameStart_q <= latch;
      if (tick) begin
        div_q  <= '0;
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        hs_q   <= hs_d;
        vs_q   <= vs_d;
        rgb_q  <= rgb_d;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (latch) begin
        birdY_q   <= bus.bird_y[9:0];
        pipe1_q   <= bus.pipe1[27:0];
        pipe2_q   <= bus.pipe2[27:0];
        pipe3_q   <= bus.pipe3[27:0];
        coinVis_q <= bus.coin[31];
        coin_q    <= bus.coin[19:0];
        status_q  <= bus.status;
      end
    end
  end

  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.rgb         = rgb_q;
  assign bus.frame_start = frameStart_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Bench for frame_renderer on a shrunken VGA geometry: a per-pixel scoreboard
// from a behavioural model plus fixed-colour spot checks at chosen pixels.
module tb_frame_renderer;
  localparam int PIX_DIV = 2;
  localparam int H_VIS = 64, H_FP = 2, H_SYNC = 6, H_BP = 2;
  localparam int V_VIS = 40, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;

  localparam logic [11:0] COL_SKY  = 12'h7CF;
  localparam logic [11:0] COL_PIPE = 12'h2A2;
  localparam logic [11:0] COL_BIRD = 12'hFD0;
  localparam logic [11:0] COL_COIN = 12'hFA0;
  localparam logic [11:0] COL_DUAL = 12'h00F;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   totalChecks = 0;
  int   badChecks   = 0;

  int          mDiv = 0, mH = 0, mV = 0, lastH = 0, lastV = 0, clkCount = 0;
  int          sBird = 240;
  logic [31:0] sPipe [3];
  logic [31:0] sCoin = '0;
  logic [1:0]  sStatus = 2'b00;
  logic [13:0] expQ [$];
  logic [13:0] expWant;
  logic        fsWant;
  event        pixOut;

  logic [15:0] sceneBird;
  logic [31:0] sceneP1, sceneP2, sceneP3, sceneCoin;

  frame_renderer_if bus ();

  frame_renderer #(
    .PIX_DIV(PIX_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mkPipe(input int gap, input int x, input int y);
    return {4'b0000, 8'(gap), 10'(x), 10'(y)};
  endfunction

  function automatic logic [31:0] mkCoin(input logic vis, input int x, input int y);
    return {vis, 11'b0, 10'(y), 10'(x)};
  endfunction

  function automatic logic hsModel(input int h);
    return !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
  endfunction

  function automatic logic vsModel(input int v);
    return !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
  endfunction

  function automatic logic [11:0] pixModel(input int h, input int v);
    int wy, px, py, gp, cx, cy;
    if (h >= H_VIS || v >= V_VIS) return 12'h000;
    if (sStatus == 2'b11 && (h < 4 || h >= H_VIS - 4 || v < 4 || v >= V_VIS - 4)) return COL_DUAL;
    wy = V_VIS - 1 - v;
    if (h >= 40 && h <= 55 && wy >= sBird && wy <= sBird + 15) return COL_BIRD;
    cx = int'(sCoin[9:0]);
    cy = int'(sCoin[19:10]);
    if (sCoin[31] && h >= cx && h < cx + 16 && wy >= cy && wy < cy + 16) return COL_COIN;
    for (int k = 0; k < 3; k++) begin
      px = int'(sPipe[k][19:10]);
      py = int'(sPipe[k][9:0]);
      gp = int'(sPipe[k][27:20]);
      if (h >= px && h < px + 50 && (wy <= py || wy >= py + gp)) return COL_PIPE;
    end
    return COL_SKY;
  endfunction

  // Model runs in lockstep; on each pixel tick the expected output is queued
  // and then popped against what the DUT registered on that same edge.
  always @(posedge clk) begin
    #1;
    clkCount++;
    if (!rst_n) begin
      mDiv = 0; mH = 0; mV = 0;
      sBird = 240; sPipe[0] = '0; sPipe[1] = '0; sPipe[2] = '0;
      sCoin = '0; sStatus = 2'b00;
      expQ.delete();
    end else begin
      fsWant = 1'b0;
      if (mDiv == PIX_DIV - 1) begin
        mDiv = 0;
        expQ.push_back({hsModel(mH), vsModel(mV), pixModel(mH, mV)});
        if (mH == 0 && mV == V_VIS) begin
          fsWant = 1'b1;
          sBird = int'(bus.bird_y[9:0]);
          sPipe[0] = bus.pipe1; sPipe[1] = bus.pipe2; sPipe[2] = bus.pipe3;
          sCoin = bus.coin; sStatus = bus.status;
        end
        lastH = mH; lastV = mV;
        mH++;
        if (mH == H_TOTAL) begin
          mH = 0; mV++;
          if (mV == V_TOTAL) mV = 0;
        end
        expWant = expQ.pop_front();
        checkOutput($sformatf("pix(%0d,%0d)", lastH, lastV), {bus.hs, bus.vs, bus.rgb}, expWant);
        ->pixOut;
      end else begin
        mDiv++;
      end
      checkOutput("frame_start", bus.frame_start, fsWant);
    end
  end

  task automatic applyStimulus(input logic [15:0] bird, input logic [31:0] p1, input logic [31:0] p2,
                               input logic [31:0] p3, input logic [31:0] c, input logic [1:0] st);
    @(negedge clk);
    bus.bird_y = bird; bus.pipe1 = p1; bus.pipe2 = p2; bus.pipe3 = p3;
    bus.coin = c; bus.status = st;
  endtask

  task automatic spotCheck(input string tag, input int h, input int v, input logic [11:0] want);
    int   n = 0;
    logic found = 1'b0;
    while (!found && n < FRAME_TICKS + 8) begin
      @(pixOut);
      found = (lastH == h && lastV == v);
      n++;
    end
    if (found) checkOutput(tag, bus.rgb, want);
    else checkOutput({tag, "_timeout"}, found, 1'b1);
  endtask

  task automatic waitFrameStart(input string tag);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < FRAME_TICKS + 8) begin
      @(pixOut);
      seen = bus.frame_start;
      n++;
    end
    if (!seen) checkOutput({tag, "_timeout"}, seen, 1'b1);
  endtask

  initial begin
    #960000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalChecks, badChecks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t1, hsLow, vsLow, n, relCount;
    logic seen;

    sceneBird = 16'h8000 | 16'd14;
    sceneP1   = mkPipe(10, 8, 10);
    sceneP2   = mkPipe(5, 70, 3);
    sceneP3   = mkPipe(0, 70, 0);
    sceneCoin = mkCoin(1'b1, 45, 18);
    bus.bird_y = sceneBird; bus.pipe1 = sceneP1; bus.pipe2 = sceneP2; bus.pipe3 = sceneP3;
    bus.coin = sceneCoin; bus.status = 2'b00;

    @(posedge clk); #1;
    checkOutput("rst_rgb", bus.rgb, 12'h000);
    checkOutput("rst_hs", bus.hs, 1'b1);
    checkOutput("rst_vs", bus.vs, 1'b1);
    checkOutput("rst_fs", bus.frame_start, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] timing over one frame");
    waitFrameStart("fs1");
    t1 = clkCount; hsLow = !bus.hs; vsLow = !bus.vs; n = 1; seen = 1'b0;
    while (!seen && n < FRAME_TICKS + 8) begin
      @(pixOut);
      if (bus.frame_start) seen = 1'b1;
      else begin
        hsLow += int'(!bus.hs);
        vsLow += int'(!bus.vs);
        n++;
      end
    end
    checkOutput("fs_seen", seen, 1'b1);
    checkOutput("fs_period", clkCount - t1, FRAME_TICKS * PIX_DIV);
    checkOutput("hs_low_ticks", hsLow, H_SYNC * V_TOTAL);
    checkOutput("vs_low_ticks", vsLow, V_SYNC * H_TOTAL);

    $display("[TB] scene: bird, pipe, coin");
    spotCheck("coin_top", 58, 8, COL_COIN);
    spotCheck("bird_over_coin", 45, 15, COL_BIRD);
    spotCheck("coin_right", 58, 15, COL_COIN);
    spotCheck("pipe_gap_top", 10, 19, COL_PIPE);
    spotCheck("gap_top_sky", 10, 20, COL_SKY);
    spotCheck("left_of_bird", 39, 22, COL_SKY);
    spotCheck("bird_left", 40, 22, COL_BIRD);
    spotCheck("bird_right", 55, 22, COL_BIRD);
    spotCheck("right_of_bird", 56, 22, COL_SKY);
    spotCheck("bird_bottom", 40, 25, COL_BIRD);
    spotCheck("below_bird", 40, 26, COL_SKY);
    spotCheck("gap_bottom_sky", 10, 28, COL_SKY);
    spotCheck("pipe_gap_bottom", 10, 29, COL_PIPE);

    $display("[TB] coin cleared mid-frame");
    spotCheck("coin_before_clear", 58, 8, COL_COIN);
    applyStimulus(sceneBird, sceneP1, sceneP2, sceneP3, mkCoin(1'b0, 45, 18), 2'b00);
    spotCheck("coin_held", 58, 15, COL_COIN);
    waitFrameStart("fs_coin");
    spotCheck("coin_gone", 58, 15, COL_SKY);

    $display("[TB] dual border");
    applyStimulus(sceneBird, sceneP1, sceneP2, sceneP3, mkCoin(1'b0, 45, 18), 2'b11);
    waitFrameStart("fs_dual");
    spotCheck("dual_00", 0, 0, COL_DUAL);
    spotCheck("dual_2_20", 2, 20, COL_DUAL);
    spotCheck("dual_corner", H_VIS - 1, V_VIS - 1, COL_DUAL);
    applyStimulus(sceneBird, sceneP1, sceneP2, sceneP3, mkCoin(1'b0, 45, 18), 2'b00);
    waitFrameStart("fs_single");
    spotCheck("single_00", 0, 0, COL_SKY);
    spotCheck("single_2_20", 2, 20, COL_SKY);
    spotCheck("single_corner", H_VIS - 1, V_VIS - 1, COL_SKY);

    $display("[TB] reset mid-frame");
    spotCheck("pre_reset", 10, 30, COL_PIPE);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rgb", bus.rgb, 12'h000);
    checkOutput("async_hs", bus.hs, 1'b1);
    checkOutput("async_vs", bus.vs, 1'b1);
    checkOutput("async_fs", bus.frame_start, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    relCount = clkCount;
    spotCheck("first_pix", 0, 0, COL_PIPE);
    checkOutput("first_tick_delay", clkCount - relCount, PIX_DIV);
    spotCheck("shadow_reset", 45, 15, COL_PIPE);
    waitFrameStart("fs_relatch");
    spotCheck("bird_relatched", 45, 15, COL_BIRD);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
